// File: rtl/grid_move_sched_pkg.sv
// Shared encodings for the two-player tile move scheduler: FSM states,
// move directions, default grid size and the tile bit-index helper.
package grid_move_sched_pkg;

    localparam int unsigned HMAXTILE_DEF = 9;
    localparam int unsigned VMAXTILE_DEF = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARB    = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_U = 2'd3
    } dir_e;

    // Row-major walkable-map index; rows grow downward.
    function automatic int unsigned tile_idx(input int unsigned hmax,
                                             input logic [4:0]  h,
                                             input logic [4:0]  v);
        return (hmax + 32'd1) * 32'(v) + 32'(h);
    endfunction

endpackage

// File: rtl/grid_move_sched_if.sv
// Request/position bundle between keyboard decoder, scheduler and renderer.
// Requests are level-held by the decoder; moved/blocked are single-cycle pulses.
interface grid_move_sched_if #(
    parameter int unsigned HMAXTILE = 9,
    parameter int unsigned VMAXTILE = 5
);
    localparam int unsigned NTILE = (HMAXTILE + 1) * (VMAXTILE + 1);

    logic [1:0]       req_l;
    logic [1:0]       req_r;
    logic [1:0]       req_d;
    logic [1:0]       req_u;
    logic [NTILE-1:0] walkAble;
    logic [3:0]       p0h;
    logic [3:0]       p0v;
    logic [3:0]       p1h;
    logic [3:0]       p1v;
    logic [1:0]       moved;
    logic [1:0]       blocked;
    logic             busy;
    logic [1:0]       dbg_state;
    logic             dbg_ptr;

    modport master (
        output req_l, req_r, req_d, req_u, walkAble,
        input  p0h, p0v, p1h, p1v, moved, blocked, busy, dbg_state, dbg_ptr
    );

    modport slave (
        input  req_l, req_r, req_d, req_u, walkAble,
        output p0h, p0v, p1h, p1v, moved, blocked, busy, dbg_state, dbg_ptr
    );

endinterface

// File: rtl/grid_move_sched_move_cooldown.sv
// Per-player move cooldown: loads on a committed move, counts down to zero
// and holds there; zero_o means the player may request again.
module grid_move_sched_move_cooldown #(
    parameter int unsigned CD_W      = 25,
    parameter int unsigned CD_CYCLES = 16777216
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic zero_o
);
    logic [CD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CD_W'(CD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/grid_move_sched.sv
// Two-player tile move scheduler: round-robin grant, one legality check
// (bounds, walkable map, other player) and commit, one move in flight.
module grid_move_sched
    import grid_move_sched_pkg::*;
#(
    parameter int unsigned HMAXTILE  = HMAXTILE_DEF,
    parameter int unsigned VMAXTILE  = VMAXTILE_DEF,
    parameter int unsigned CD_W      = 25,
    parameter int unsigned CD_CYCLES = 16777216
) (
    input  logic             clk,
    input  logic             rst,
    grid_move_sched_if.slave bus
);
    localparam int unsigned NTILE = (HMAXTILE + 1) * (VMAXTILE + 1);
    localparam int unsigned IDX_W = $clog2(NTILE);

    logic [1:0]      state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic            legal_q, legal_d;
    dir_e            dir_q, dir_d;
    logic [1:0][3:0] ph_q, ph_d;
    logic [1:0][3:0] pv_q, pv_d;
    logic [1:0]      moved_q, moved_d;
    logic [1:0]      blocked_q, blocked_d;
    logic [1:0]      cd_zero, cd_load;
    logic [1:0]      req_any, elig;

    assign req_any = bus.req_l | bus.req_r | bus.req_d | bus.req_u;
    assign elig    = req_any & cd_zero;

    grid_move_sched_move_cooldown #(.CD_W(CD_W), .CD_CYCLES(CD_CYCLES)) u_cd0 (
        .clk    (clk),
        .rst    (rst),
        .load_i (cd_load[0]),
        .zero_o (cd_zero[0])
    );

    grid_move_sched_move_cooldown #(.CD_W(CD_W), .CD_CYCLES(CD_CYCLES)) u_cd1 (
        .clk    (clk),
        .rst    (rst),
        .load_i (cd_load[1]),
        .zero_o (cd_zero[1])
    );

    // Pointer's player wins if eligible; requests may have dropped since IDLE.
    logic arb_ok, arb_gnt;
    dir_e arb_dir;
    always_comb begin
        arb_ok  = 1'b1;
        arb_gnt = ptr_q;
        if (!elig[ptr_q]) begin
            arb_gnt = ~ptr_q;
            arb_ok  = elig[~ptr_q];
        end
        arb_dir = DIR_U;
        if (bus.req_l[arb_gnt])      arb_dir = DIR_L;
        else if (bus.req_r[arb_gnt]) arb_dir = DIR_R;
        else if (bus.req_d[arb_gnt]) arb_dir = DIR_D;
    end

    // 5-bit target so stepping off the 0 edge lands at 31, never wraps in range.
    logic [4:0]       cur_h, cur_v, th, tv;
    logic             in_range, walk_ok, occupied;
    logic [IDX_W-1:0] tidx;
    always_comb begin
        cur_h = {1'b0, ph_q[gnt_q]};
        cur_v = {1'b0, pv_q[gnt_q]};
        th    = cur_h;
        tv    = cur_v;
        case (dir_q)
            DIR_L:   th = cur_h - 5'd1;
            DIR_R:   th = cur_h + 5'd1;
            DIR_D:   tv = cur_v + 5'd1;
            DIR_U:   tv = cur_v - 5'd1;
            default: th = cur_h;
        endcase
        in_range = (th <= 5'(HMAXTILE)) && (tv <= 5'(VMAXTILE));
        tidx     = in_range ? IDX_W'(tile_idx(HMAXTILE, th, tv)) : '0;
        walk_ok  = in_range && bus.walkAble[tidx];
        occupied = (th == {1'b0, ph_q[~gnt_q]}) && (tv == {1'b0, pv_q[~gnt_q]});
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        dir_d     = dir_q;
        legal_d   = legal_q;
        ph_d      = ph_q;
        pv_d      = pv_q;
        moved_d   = '0;
        blocked_d = '0;
        cd_load   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (arb_ok) begin
                    gnt_d   = arb_gnt;
                    dir_d   = arb_dir;
                    ptr_d   = ~arb_gnt;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                legal_d = walk_ok && !occupied;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Positions are unchanged since CHECK, so th/tv still hold the target.
                if (legal_q) begin
                    ph_d[gnt_q]    = th[3:0];
                    pv_d[gnt_q]    = tv[3:0];
                    moved_d[gnt_q] = 1'b1;
                    cd_load[gnt_q] = 1'b1;
                end else begin
                    blocked_d[gnt_q] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            dir_q     <= DIR_L;
            legal_q   <= 1'b0;
            ph_q[0]   <= 4'd0;
            pv_q[0]   <= 4'd0;
            ph_q[1]   <= 4'(HMAXTILE);
            pv_q[1]   <= 4'(VMAXTILE);
            moved_q   <= '0;
            blocked_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            dir_q     <= dir_d;
            legal_q   <= legal_d;
            ph_q      <= ph_d;
            pv_q      <= pv_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign bus.p0h       = ph_q[0];
    assign bus.p0v       = pv_q[0];
    assign bus.p1h       = ph_q[1];
    assign bus.p1v       = pv_q[1];
    assign bus.moved     = moved_q;
    assign bus.blocked   = blocked_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;
    assign bus.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_grid_move_sched.sv
// Directed bench for grid_move_sched on the 10x6 grid with a 4-cycle cooldown;
// inputs driven and outputs sampled on the falling clock edge.
module tb_grid_move_sched;
    import grid_move_sched_pkg::*;

    localparam int unsigned HMAX = 9;
    localparam int unsigned VMAX = 5;
    localparam int unsigned CD   = 4;

    logic clk = 1'b0;
    logic rst;

    grid_move_sched_if #(.HMAXTILE(HMAX), .VMAXTILE(VMAX)) bus ();

    grid_move_sched #(
        .HMAXTILE (HMAX),
        .VMAXTILE (VMAX),
        .CD_W     (25),
        .CD_CYCLES(CD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_req();
        bus.req_l = '0;
        bus.req_r = '0;
        bus.req_d = '0;
        bus.req_u = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_req();
        bus.walkAble = '1;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_pulse(input string tag, output logic [1:0] mv, output logic [1:0] bl);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick(1);
            if ((bus.moved | bus.blocked) != 2'b00) seen = 1'b1;
        end
        mv = bus.moved;
        bl = bus.blocked;
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] mv, bl, acc;
        int prev_c;
        clear_req();
        bus.walkAble = '1;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(3);
        check_val("rst_p0h", bus.p0h, 4'd0);
        check_val("rst_p0v", bus.p0v, 4'd0);
        check_val("rst_p1h", bus.p1h, 4'd9);
        check_val("rst_p1v", bus.p1v, 4'd5);
        check_val("rst_pulses", {bus.moved, bus.blocked}, 4'h0);
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_ptr", bus.dbg_ptr, 1'b0);
        rst = 1'b1;
        tick(1);

        // Latency and cooldown spacing with a held right request.
        bus.req_r = 2'b01;
        tick(1); check_val("lat_arb", bus.dbg_state, ST_ARB);
        tick(1); check_val("lat_check", bus.dbg_state, ST_CHECK);
        tick(1); check_val("lat_commit", bus.dbg_state, ST_COMMIT);
                 check_val("lat_p0h_early", bus.p0h, 4'd0);
        tick(1); check_val("lat_p0h", bus.p0h, 4'd1);
                 check_val("lat_moved", bus.moved, 2'b01);
                 check_val("lat_busy_idle", bus.busy, 1'b0);
        tick(1); check_val("lat_moved_pulse", bus.moved, 2'b00);
        tick(3); check_val("cd_still_idle", bus.busy, 1'b0);
        tick(1); check_val("cd_restart", bus.busy, 1'b1);
        tick(2); check_val("cd_p0h_hold", bus.p0h, 4'd1);
        tick(1); check_val("cd_p0h_next", bus.p0h, 4'd2);
        clear_req();

        // Left at column 0 is out of range; no cooldown so the retry is immediate.
        do_reset();
        bus.req_l = 2'b01;
        tick(4);
        check_val("edge_blocked", bus.blocked, 2'b01);
        check_val("edge_moved", bus.moved, 2'b00);
        check_val("edge_p0h", bus.p0h, 4'd0);
        tick(1); check_val("edge_retry_busy", bus.busy, 1'b1);
        tick(3); check_val("edge_retry_blocked", bus.blocked, 2'b01);
        clear_req();

        // Non-walkable tile (0,1), then the map is restored before the retry's CHECK.
        do_reset();
        bus.walkAble[10] = 1'b0;
        bus.req_d = 2'b01;
        tick(4);
        check_val("wall_blocked", bus.blocked, 2'b01);
        check_val("wall_p0v", bus.p0v, 4'd0);
        bus.walkAble[10] = 1'b1;
        tick(4);
        check_val("wall_retry_moved", bus.moved, 2'b01);
        check_val("wall_retry_p0v", bus.p0v, 4'd1);
        clear_req();

        // Walk p0 to (8,5), next to p1 at (9,5).
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i < 8) bus.req_r = 2'b01;
            else       bus.req_d = 2'b01;
            wait_pulse("walk", mv, bl);
            check_val("walk_moved", {mv, bl}, 4'b0100);
            clear_req();
        end
        check_val("walk_p0h", bus.p0h, 4'd8);
        check_val("walk_p0v", bus.p0v, 4'd5);
        bus.req_r = 2'b10;
        wait_pulse("p1_right", mv, bl);
        check_val("p1_right_blocked", {mv, bl}, 4'b0010);
        check_val("p1_right_ptr", bus.dbg_ptr, 1'b0);
        clear_req();
        bus.req_r = 2'b01;
        bus.req_l = 2'b10;
        wait_pulse("occ_a", mv, bl);
        check_val("occ_a_blocked", {mv, bl}, 4'b0001);
        check_val("occ_a_ptr", bus.dbg_ptr, 1'b1);
        wait_pulse("occ_b", mv, bl);
        check_val("occ_b_blocked", {mv, bl}, 4'b0010);
        check_val("occ_b_ptr", bus.dbg_ptr, 1'b0);
        clear_req();
        check_val("occ_p0h", bus.p0h, 4'd8);
        check_val("occ_p1h", bus.p1h, 4'd9);

        // Both players held: strict alternation, one round every 4 cycles.
        do_reset();
        for (int r = 0; r < 25; r++) begin
            if (r < 18) exp_q.push_back((r % 2 == 0) ? 4'b0100 : 4'b1000);
            else        exp_q.push_back((r % 2 == 0) ? 4'b0001 : 4'b0010);
        end
        bus.req_r = 2'b01;
        bus.req_l = 2'b10;
        prev_c = 0;
        for (int c = 1; c <= 102; c++) begin
            tick(1);
            if ((bus.moved | bus.blocked) != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check_val("alt_extra", {bus.moved, bus.blocked}, 4'h0);
                end else begin
                    check_val("alt_seq", {bus.moved, bus.blocked}, exp_q.pop_front());
                end
                check_val("alt_gap", c - prev_c, 4);
                prev_c = c;
            end
        end
        clear_req();
        check_val("alt_left", exp_q.size(), 0);
        check_val("alt_p0h", bus.p0h, 4'd9);
        check_val("alt_p1h", bus.p1h, 4'd0);

        // Reset asserted while a legal move sits in CHECK.
        do_reset();
        bus.req_r = 2'b01;
        tick(2);
        check_val("mid_check_state", bus.dbg_state, ST_CHECK);
        rst = 1'b0;
        #1;
        check_val("mid_rst_state", bus.dbg_state, ST_IDLE);
        check_val("mid_rst_busy", bus.busy, 1'b0);
        check_val("mid_rst_p0h", bus.p0h, 4'd0);
        clear_req();
        tick(2);
        rst = 1'b1;
        acc = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            acc = acc | bus.moved | bus.blocked;
        end
        check_val("mid_rst_no_pulse", acc, 2'b00);
        check_val("mid_rst_p0h_after", bus.p0h, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
